// File: rtl/sdram_pkg.sv
// Shared SDRAM port defaults and the frame-writer state encoding.
package sdram_pkg;

  localparam int SDRAM_DATA_WIDTH_DEF = 256;
  localparam int SDRAM_ADDR_WIDTH_DEF = 27;
  // 1920x1080 pixels at 4 bytes each, packed into 32-byte SDRAM words
  localparam int FRAME_WORDS_1080P    = (1920 * 1080 * 4) / 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_BURST,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous show-ahead FIFO: dout_o always shows the head word, count_o the fill level.
module sync_fifo_fwft #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_ONE;
      if (pop_i)  rd_q <= rd_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CNT_FULL);
  assign count_o = cnt_q;

endmodule

// File: rtl/sdram_frame_writer.sv
// Avalon-MM burst write master: buffers a word stream and writes one frame as fixed bursts.
// Define SDRAM_WRITER_PINGPONG_EN to alternate frames between base and base+FRAME_WORDS.
module sdram_frame_writer
  import sdram_pkg::*;
#(
  parameter int SDRAM_DATA_WIDTH = SDRAM_DATA_WIDTH_DEF,
  parameter int SDRAM_ADDR_WIDTH = SDRAM_ADDR_WIDTH_DEF,
  parameter int BURST_LEN        = 16,
  parameter int FRAME_WORDS      = FRAME_WORDS_1080P,
  parameter int FIFO_DEPTH       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start_i,
  input  logic [SDRAM_ADDR_WIDTH-1:0]   base_addr_i,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          buf_sel_o,
  input  logic [SDRAM_DATA_WIDTH-1:0]   st_data_i,
  input  logic                          st_valid_i,
  output logic                          st_ready_o,
  output logic [SDRAM_ADDR_WIDTH-1:0]   sdram_address_o,
  output logic [7:0]                    sdram_burstcount_o,
  output logic [SDRAM_DATA_WIDTH-1:0]   sdram_writedata_o,
  output logic [SDRAM_DATA_WIDTH/8-1:0] sdram_byteenable_o,
  output logic                          sdram_write_o,
  input  logic                          sdram_waitrequest_i
);

  localparam int RW = $clog2(FRAME_WORDS + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [RW-1:0] FRAME_CNT = RW'(FRAME_WORDS);
  localparam logic [RW-1:0] RW_ONE    = 1;

  wr_state_e                 state_q;
  logic [SDRAM_ADDR_WIDTH-1:0] addr_q;
  logic [RW-1:0]             remaining_q, accepted_q;
  logic [7:0]                bcnt_q, beat_q;
  logic                      write_q, done_q;

  logic [CW-1:0]             fifo_cnt;
  logic                      fifo_full, push, beat, frame_end;
  logic [SDRAM_DATA_WIDTH-1:0] fifo_head;
  logic [31:0]               rem32;
  logic [7:0]                cur_len;
  logic [SDRAM_ADDR_WIDTH-1:0] start_addr;

  assign rem32      = 32'(remaining_q);
  assign cur_len    = (rem32 >= 32'(BURST_LEN)) ? 8'(BURST_LEN) : rem32[7:0];
  assign st_ready_o = (state_q != ST_IDLE) && !fifo_full && (accepted_q < FRAME_CNT);
  assign push       = st_valid_i && st_ready_o;
  assign beat       = write_q && !sdram_waitrequest_i;
  assign frame_end  = beat && (beat_q == bcnt_q - 8'd1) && (remaining_q == RW'(bcnt_q));

  sync_fifo_fwft #(
    .WIDTH (SDRAM_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (st_data_i),
    .pop_i   (beat),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

`ifdef SDRAM_WRITER_PINGPONG_EN
  logic side_q, buf_sel_q;

  assign start_addr = side_q ? base_addr_i + SDRAM_ADDR_WIDTH'(FRAME_WORDS) : base_addr_i;
  assign buf_sel_o  = buf_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      side_q    <= 1'b0;
      buf_sel_q <= 1'b0;
    end else if (frame_end) begin
      buf_sel_q <= side_q;
      side_q    <= ~side_q;
    end
  end
`else
  assign start_addr = base_addr_i;
  assign buf_sel_o  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      accepted_q  <= '0;
      bcnt_q      <= '0;
      beat_q      <= '0;
      write_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) accepted_q <= accepted_q + RW_ONE;
      case (state_q)
        ST_IDLE: if (frame_start_i) begin
          addr_q      <= start_addr;
          remaining_q <= FRAME_CNT;
          accepted_q  <= '0;
          state_q     <= ST_FILL;
        end
        // burst parameters freeze here so they stay constant through stalls
        ST_FILL: if (32'(fifo_cnt) >= 32'(cur_len)) begin
          bcnt_q  <= cur_len;
          beat_q  <= '0;
          write_q <= 1'b1;
          state_q <= ST_BURST;
        end
        ST_BURST: if (beat) begin
          beat_q <= beat_q + 8'd1;
          if (beat_q == bcnt_q - 8'd1) begin
            write_q     <= 1'b0;
            addr_q      <= addr_q + SDRAM_ADDR_WIDTH'(bcnt_q);
            remaining_q <= remaining_q - RW'(bcnt_q);
            if (remaining_q == RW'(bcnt_q)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FILL;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o             = (state_q != ST_IDLE);
  assign frame_done_o       = done_q;
  assign sdram_address_o    = addr_q;
  assign sdram_burstcount_o = bcnt_q;
  assign sdram_writedata_o  = write_q ? fifo_head : '0;
  assign sdram_byteenable_o = '1;
  assign sdram_write_o      = write_q;

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed bench for sdram_frame_writer: 40-word frames, 16-beat bursts, stalls, reset mid-burst.
module tb_sdram_frame_writer;

  localparam int DW = 32, AW = 27, BL = 16, FW = 40, FD = 32;

  logic          clk = 1'b0, rst = 1'b1, frame_start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, frame_done, buf_sel, st_ready, sdram_write;
  logic [DW-1:0] st_data = '0, wdata;
  logic          st_valid = 1'b0, sdram_wait = 1'b0;
  logic [AW-1:0] addr;
  logic [7:0]    bc;
  logic [DW/8-1:0] be;

  always #5 clk = ~clk;

  sdram_frame_writer #(
    .SDRAM_DATA_WIDTH (DW), .SDRAM_ADDR_WIDTH (AW), .BURST_LEN (BL),
    .FRAME_WORDS (FW), .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk), .rst (rst), .frame_start_i (frame_start), .base_addr_i (base_addr),
    .busy_o (busy), .frame_done_o (frame_done), .buf_sel_o (buf_sel),
    .st_data_i (st_data), .st_valid_i (st_valid), .st_ready_o (st_ready),
    .sdram_address_o (addr), .sdram_burstcount_o (bc), .sdram_writedata_o (wdata),
    .sdram_byteenable_o (be), .sdram_write_o (sdram_write), .sdram_waitrequest_i (sdram_wait)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // source and slave stall driver
  int cyc = 0, src_period = 1, src_word = 0;
  bit stall_en = 0, hs = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (hs) src_word++;
    st_valid   = ((cyc % src_period) == 0);
    st_data    = DW'(src_word);
    sdram_wait = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // bus monitor
  logic [AW-1:0]  b_addr[$];
  logic [7:0]     b_bc[$];
  logic [DW-1:0]  beats[$];
  bit in_burst = 0, was_stall = 0;
  int bib = 0, cur_bc = 0, drop_cnt = 0, done_cnt = 0, pushed = 0, beat_total = 0;
  int last_beat_cyc = 0, done_cyc = 0;
  logic [127:0] stall_snap = '0;

  always @(negedge clk) begin
    hs = st_valid && st_ready;
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
    if (sdram_write) begin
      if (!in_burst) begin
        in_burst = 1; bib = 0; cur_bc = int'(bc);
        b_addr.push_back(addr);
        b_bc.push_back(bc);
        chk("buffered_before_burst", 128'(pushed - beat_total >= cur_bc), 128'(1));
      end else if (was_stall) begin
        chk("stall_hold", 128'({addr, bc, wdata}), stall_snap);
      end
      if (sdram_wait) begin
        was_stall  = 1;
        stall_snap = 128'({addr, bc, wdata});
      end else begin
        was_stall = 0;
        beats.push_back(wdata);
        bib++; beat_total++;
        last_beat_cyc = cyc;
        if (bib >= cur_bc) in_burst = 0;
      end
    end else begin
      if (in_burst) drop_cnt++;
      was_stall = 0;
    end
    if (hs) pushed++;
  end

  task automatic mon_clear();
    b_addr.delete(); b_bc.delete(); beats.delete();
    in_burst = 0; was_stall = 0; bib = 0; drop_cnt = 0; done_cnt = 0;
    pushed = 0; beat_total = 0;
  endtask

  task automatic start_frame(input logic [AW-1:0] b);
    @(posedge clk); #2;
    frame_start = 1'b1; base_addr = b;
    @(posedge clk); #2;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin @(posedge clk); n++; end
    chk({nm, "_done_seen"}, 128'(done_cnt != 0), 128'(1));
    repeat (4) @(posedge clk);
    #2;
  endtask

  bit pp_side = 0;

  task automatic check_frame(input string nm, input logic [AW-1:0] b, input int w0);
    logic [AW-1:0] eb = b;
    logic exp_sel = 1'b0;
`ifdef SDRAM_WRITER_PINGPONG_EN
    if (pp_side) eb = b + AW'(FW);
    exp_sel = pp_side;
`endif
    chk({nm, "_nbursts"}, 128'(b_addr.size()), 128'(3));
    for (int i = 0; i < 3 && i < int'(b_addr.size()); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 128'(b_addr[i]), 128'(eb + AW'(16 * i)));
      chk($sformatf("%s_bc%0d", nm, i), 128'(b_bc[i]), 128'((i < 2) ? 16 : 8));
    end
    chk({nm, "_nbeats"}, 128'(beats.size()), 128'(FW));
    for (int i = 0; i < int'(beats.size()) && i < FW; i++)
      chk($sformatf("%s_data%0d", nm, i), 128'(beats[i]), 128'(DW'(w0 + i)));
    chk({nm, "_done_pulses"}, 128'(done_cnt), 128'(1));
    chk({nm, "_done_latency"}, 128'(done_cyc - last_beat_cyc), 128'(1));
    chk({nm, "_buf_sel"}, 128'(buf_sel), 128'(exp_sel));
    chk({nm, "_write_drop"}, 128'(drop_cnt), 128'(0));
    pp_side = !pp_side;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, n;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(frame_done), 128'(0));
    chk("rst_buf_sel", 128'(buf_sel), 128'(0));
    chk("rst_ready", 128'(st_ready), 128'(0));
    chk("rst_write", 128'(sdram_write), 128'(0));
    chk("rst_addr", 128'(addr), 128'(0));
    chk("rst_bc", 128'(bc), 128'(0));
    chk("rst_wdata", 128'(wdata), 128'(0));
    chk("rst_be", 128'(be), 128'(4'hf));
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);

    // continuous source, no stalls; busy one cycle after start
    mon_clear(); w0 = src_word;
    @(posedge clk); #2;
    chk("pre_start_busy", 128'(busy), 128'(0));
    frame_start = 1'b1; base_addr = 27'h100;
    @(posedge clk); #2;
    chk("start_busy", 128'(busy), 128'(1));
    frame_start = 1'b0;
    wait_done("f1");
    chk("f1_idle_busy", 128'(busy), 128'(0));
    check_frame("f1", 27'h100, w0);

    // random slave stalls
    mon_clear(); w0 = src_word; stall_en = 1;
    start_frame(27'h100);
    wait_done("f2");
    stall_en = 0;
    check_frame("f2", 27'h100, w0);

    // sparse source: one word in four
    mon_clear(); w0 = src_word; src_period = 4;
    start_frame(27'h100);
    wait_done("f3");
    src_period = 1;
    check_frame("f3", 27'h100, w0);

    // start pulsed mid-frame is ignored; acceptance caps at FRAME_WORDS
    mon_clear(); w0 = src_word;
    start_frame(27'h100);
    n = 0;
    while (pushed < 20 && n < 500) begin @(posedge clk); n++; end
    chk("f4_reach_20", 128'(pushed >= 20), 128'(1));
    start_frame(27'h300);
    wait_done("f4");
    repeat (5) @(posedge clk);
    chk("f4_accepted_cap", 128'(pushed), 128'(FW));
    check_frame("f4", 27'h100, w0);
    mon_clear(); w0 = src_word;
    start_frame(27'h200);
    wait_done("f5");
    check_frame("f5", 27'h200, w0);

    // reset on beat 5 of the second burst
    mon_clear();
    start_frame(27'h100);
    n = 0;
    while (n < 500) begin
      @(posedge clk); #2; n++;
      if (b_addr.size() == 2 && bib == 4) break;
    end
    chk("rst_mid_reached", 128'(b_addr.size() == 2 && bib == 4), 128'(1));
    rst = 1'b1;
    @(posedge clk); #2;
    mon_clear();
    @(negedge clk);
    chk("rst_mid_write", 128'(sdram_write), 128'(0));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_ready", 128'(st_ready), 128'(0));
    @(posedge clk); #2 rst = 1'b0;
    pp_side = 0;
    repeat (3) @(posedge clk);
    mon_clear(); w0 = src_word;
    start_frame(27'h100);
    wait_done("f6");
    chk("f6_done_after_rst", 128'(done_cnt), 128'(1));
    check_frame("f6", 27'h100, w0);

    // second frame after reset: ping-pong moves to the other buffer
    mon_clear(); w0 = src_word;
    start_frame(27'h100);
    wait_done("f7");
    check_frame("f7", 27'h100, w0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_frame_writer.md
# sdram_frame_writer

Avalon-MM burst write master for the FPGA-to-HPS SDRAM port, the write-side counterpart of the frame reader that feeds the HDMI pixel path. It accepts a valid/ready stream of SDRAM-width words, buffers them in a small show-ahead FIFO, and writes one frame of `FRAME_WORDS` words into SDRAM as fixed-length bursts starting at a base word address. It sits in the fabric clock domain, alongside the reader on the f2h_sdram interface.

## Interface
- `SDRAM_DATA_WIDTH`, 256: stream and SDRAM word width.
- `SDRAM_ADDR_WIDTH`, 27: SDRAM word address width.
- `BURST_LEN`, 16: maximum beats per burst, 1..128.
- `FRAME_WORDS`, 259200: words per frame. Must be ≥ 1.
- `FIFO_DEPTH`, 32: buffer depth. Power of two, ≥ 2×`BURST_LEN`.
- `clk` in 1: fabric clock. One clock only.
- `rst` in 1: reset, synchronous, active-high.
- `frame_start_i` in 1: one-cycle start request.
- `base_addr_i` in `SDRAM_ADDR_WIDTH`: frame base word address, sampled on start.
- `busy_o` out 1: a frame is in progress.
- `frame_done_o` out 1: one-cycle pulse when the last beat of the frame is accepted.
- `buf_sel_o` out 1: buffer of the last completed frame.
- `st_data_i` in `SDRAM_DATA_WIDTH`: stream data.
- `st_valid_i` in 1: stream valid.
- `st_ready_o` out 1: stream ready.
- `sdram_address_o` out `SDRAM_ADDR_WIDTH`: burst start address.
- `sdram_burstcount_o` out 8: burst length.
- `sdram_writedata_o` out `SDRAM_DATA_WIDTH`: write data, taken from the FIFO head.
- `sdram_byteenable_o` out `SDRAM_DATA_WIDTH`/8: constant all-ones.
- `sdram_write_o` out 1: write request.
- `sdram_waitrequest_i` in 1: slave stall.

## Operation
- States: IDLE, FILL, BURST, DONE.
- **IDLE**
  - On `frame_start_i`: latch the base address into `addr`, set `remaining`=`FRAME_WORDS` and `accepted`=0, go to FILL.
  - `frame_start_i` in any other state is ignored.
- **Stream input**
  - `st_ready_o` = (state≠IDLE) && FIFO not full && `accepted`<`FRAME_WORDS`.
  - A word is pushed when `st_valid_i` && `st_ready_o`; each push increments `accepted`.
  - Words offered while IDLE are not accepted.
- **FILL**
  - `cur_len` = min(`BURST_LEN`, `remaining`).
  - When the FIFO count ≥ `cur_len`, go to BURST.
- **BURST**
  - `sdram_write_o`=1; `sdram_address_o`=`addr` and `sdram_burstcount_o`=`cur_len` are held constant for the whole burst.
  - A beat is accepted when `sdram_write_o` && !`sdram_waitrequest_i`. Each accepted beat pops the FIFO and increments the beat counter.
  - On the last beat: `addr` += `cur_len`, `remaining` -= `cur_len`. Go to DONE if `remaining`=0, else go to FILL.
- **DONE**
  - `frame_done_o`=1 for one cycle, then go to IDLE.
- `busy_o` = (state≠IDLE).
- Arithmetic:
  - `addr` wraps modulo 2^`SDRAM_ADDR_WIDTH`.
  - `remaining` and `accepted` are wide enough to hold `FRAME_WORDS`.
  - The last burst of a frame is short when `FRAME_WORDS` mod `BURST_LEN` ≠ 0.
- FIFO full: `st_ready_o`=0. The FIFO cannot be empty mid-burst, because a burst only starts when `cur_len` words are already buffered.
- Push and pop in the same cycle is legal; the count is unchanged.

## Timing
- Reset values: state IDLE, FIFO flushed, counters 0. All outputs 0 except `sdram_byteenable_o`, which is all-ones.
- Reset mid-burst: `sdram_write_o` is 0 from the first cycle after the reset edge. The partial burst is abandoned and no completion is owed.
- Start to `busy_o`: 1 cycle.
- FILL→BURST: `sdram_write_o` rises the cycle after the FIFO count reaches `cur_len`.
- There is at least one FILL cycle between consecutive bursts.
- Beat throughput is 1 per cycle when `sdram_waitrequest_i`=0.
- `frame_done_o` fires the cycle after the final beat is accepted.
- Write data is valid in the same cycle as `sdram_write_o`; the FIFO is show-ahead.

## Configuration
- `SDRAM_WRITER_PINGPONG_EN` defined:
  - The frame base alternates between `base_addr_i` and `base_addr_i`+`FRAME_WORDS` on successive frames, starting with `base_addr_i` after reset.
  - `buf_sel_o` takes the just-written buffer index (0 or 1) at the `frame_done_o` pulse.
- Undefined:
  - Every frame is written at `base_addr_i`.
  - `buf_sel_o` is constant 0.

## Structure
- Shared package `sdram_pkg`:
  - `SDRAM_DATA_WIDTH`/`SDRAM_ADDR_WIDTH` defaults.
  - `FRAME_WORDS` constant for 1080p at 32 bpp.
  - The state enum typedef.
- One sub-module, `sync_fifo_fwft`: synchronous show-ahead FIFO with a count output, sharing `clk`/`rst`.

## Test plan
- `FRAME_WORDS`=40, `BURST_LEN`=16, base 0x100, continuous source → bursts (0x100,16), (0x110,16), (0x120,8); exactly one `frame_done_o` pulse; data written in order.
- Random `sdram_waitrequest_i` at 50% → `sdram_address_o`, `sdram_burstcount_o` and `sdram_writedata_o` stable while stalled; 40 beats total; no beat lost or duplicated.
- Source with `st_valid_i` high 1 cycle in 4 → no burst starts before 16 words are buffered; `sdram_write_o` never drops mid-burst.
- `frame_start_i` pulsed while busy at word 20 → ignored; `accepted` stops at 40; the next start begins a fresh frame at `base_addr_i`.
- `rst` asserted on beat 5 of the second burst → next cycle `sdram_write_o`=0, `busy_o`=0, `st_ready_o`=0; a new start writes from the base again.
- With `SDRAM_WRITER_PINGPONG_EN`, `FRAME_WORDS`=40, base 0x100, two frames → second frame bursts at 0x128, 0x138, 0x148; `buf_sel_o`=0 then 1.
